// File: rtl/pakin_pkg.sv
// Shared sizes, FSM state encodings and helpers for the pakin packet-to-message receiver.
// The default field sizes below give a 20-bit message carried as four 5-bit packets.
package pakin_pkg;

   localparam int PSZ_DEF = 5;
   localparam int ASZ_DEF = 6;
   localparam int DSZ_DEF = 4;
   localparam int RSZ_DEF = 4;
   localparam int FSZ_DEF = 2;

   typedef enum logic {
      I_IDLE,
      I_ACK
   } in_state_e;

   typedef enum logic [1:0] {
      O_IDLE,
      O_REQ,
      O_WAIT
   } out_state_e;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/pakin_msg_fifo.sv
// Small message FIFO with extra-MSB pointers; head is the oldest entry, read combinationally.
module msg_fifo #(
   parameter int MSZ = 20,
   parameter int FSZ = 2
) (
   input  logic           i_clk,
   input  logic           reset_n,
   input  logic           push,
   input  logic [MSZ-1:0] din,
   input  logic           pop,
   output logic [MSZ-1:0] head,
   output logic           full,
   output logic           empty
);

   logic [FSZ:0]   wr_ptr_q, wr_ptr_d;
   logic [FSZ:0]   rd_ptr_q, rd_ptr_d;
   logic [MSZ-1:0] mem_q [2**FSZ];
   logic           do_push, do_pop;

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[FSZ] != rd_ptr_q[FSZ]) &&
                  (wr_ptr_q[FSZ-1:0] == rd_ptr_q[FSZ-1:0]);
   assign head  = mem_q[rd_ptr_q[FSZ-1:0]];

   // A pop in the same cycle frees the slot a full-FIFO push lands in.
   assign do_push = push && (!full || pop);
   assign do_pop  = pop && !empty;

   always_comb begin
      wr_ptr_d = wr_ptr_q + {{FSZ{1'b0}}, do_push};
      rd_ptr_d = rd_ptr_q + {{FSZ{1'b0}}, do_pop};
   end

   always_ff @(posedge i_clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge i_clk) begin
      if (do_push) mem_q[wr_ptr_q[FSZ-1:0]] <= din;
   end

endmodule

// File: rtl/pakin.sv
// Reassembles NPK packets into a message, drops messages with a bad redundancy field,
// buffers good ones and offers them on a four-phase output channel.
module pakin
   import pakin_pkg::*;
#(
   parameter int PSZ = PSZ_DEF,
   parameter int ASZ = ASZ_DEF,
   parameter int DSZ = DSZ_DEF,
   parameter int RSZ = RSZ_DEF,
   parameter int FSZ = FSZ_DEF,
   localparam int MSZ = 2*ASZ + DSZ + RSZ
) (
   input  logic           i_clk,
   input  logic           reset_n,
   input  logic [PSZ-1:0] i_rcv_pakio,
   input  logic           i_rcv_req,
   output logic           o_rcv_ack,
   output logic [MSZ-1:0] o_snd_msg,
   output logic           o_snd_req,
   input  logic           i_snd_ack,
   output logic [7:0]     o_err_cnt,
   output logic [3:0]     o_dbg_leds
);

   localparam int NPK = MSZ / PSZ;
   localparam int CW  = (NPK > 1) ? $clog2(NPK) : 1;
   localparam int AW  = MSZ - PSZ;

   generate
      if ((MSZ % PSZ) != 0 || NPK < 2) begin : g_bad_size
         $error("pakin: message width must be a multiple (>=2) of the packet width");
      end
   endgenerate

   in_state_e      in_st_q, in_st_d;
   logic [CW-1:0]  pk_cnt_q, pk_cnt_d;
   logic [AW-1:0]  asm_q, asm_d;
   logic [7:0]     err_cnt_q, err_cnt_d;
   out_state_e     out_st_q, out_st_d;
   logic [MSZ-1:0] snd_msg_q, snd_msg_d;
   logic           snd_req_q, snd_req_d;

   logic [MSZ-1:0] full_msg, fifo_head;
   logic [RSZ-1:0] red_calc;
   logic           last_pk, red_ok, accept;
   logic           fifo_push, fifo_pop, fifo_full, fifo_empty;

   assign full_msg = {asm_q, i_rcv_pakio};
   assign last_pk  = (pk_cnt_q == CW'(NPK-1));
   assign red_calc = RSZ'(full_msg[MSZ-1 -: ASZ]) +
                     RSZ'(full_msg[MSZ-ASZ-1 -: ASZ]) +
                     RSZ'(full_msg[RSZ+DSZ-1 -: DSZ]);
   assign red_ok   = (red_calc == full_msg[RSZ-1:0]);

   // The last packet waits for a free slot regardless of its check outcome;
   // a pop on the same edge counts as a free slot.
   assign fifo_pop  = (out_st_q == O_REQ) && i_snd_ack;
   assign accept    = (in_st_q == I_IDLE) && i_rcv_req &&
                      !(last_pk && fifo_full && !fifo_pop);
   assign fifo_push = accept && last_pk && red_ok;

   always_comb begin
      in_st_d   = in_st_q;
      pk_cnt_d  = pk_cnt_q;
      asm_d     = asm_q;
      err_cnt_d = err_cnt_q;
      case (in_st_q)
         I_IDLE: begin
            if (accept) begin
               in_st_d  = I_ACK;
               asm_d    = full_msg[AW-1:0];
               pk_cnt_d = last_pk ? '0 : pk_cnt_q + CW'(1);
               if (last_pk && !red_ok) err_cnt_d = sat_inc8(err_cnt_q);
            end
         end
         I_ACK:   if (!i_rcv_req) in_st_d = I_IDLE;
         default: in_st_d = I_IDLE;
      endcase
   end

   always_comb begin
      out_st_d  = out_st_q;
      snd_msg_d = snd_msg_q;
      snd_req_d = snd_req_q;
      case (out_st_q)
         O_IDLE: begin
            if (!fifo_empty) begin
               out_st_d  = O_REQ;
               snd_msg_d = fifo_head;
               snd_req_d = 1'b1;
            end
         end
         O_REQ: begin
            if (i_snd_ack) begin
               out_st_d  = O_WAIT;
               snd_req_d = 1'b0;
            end
         end
         O_WAIT:  if (!i_snd_ack) out_st_d = O_IDLE;
         default: begin
            out_st_d  = O_IDLE;
            snd_req_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge reset_n) begin
      if (!reset_n) begin
         in_st_q   <= I_IDLE;
         pk_cnt_q  <= '0;
         asm_q     <= '0;
         err_cnt_q <= '0;
         out_st_q  <= O_IDLE;
         snd_msg_q <= '0;
         snd_req_q <= 1'b0;
      end else begin
         in_st_q   <= in_st_d;
         pk_cnt_q  <= pk_cnt_d;
         asm_q     <= asm_d;
         err_cnt_q <= err_cnt_d;
         out_st_q  <= out_st_d;
         snd_msg_q <= snd_msg_d;
         snd_req_q <= snd_req_d;
      end
   end

   msg_fifo #(
      .MSZ (MSZ),
      .FSZ (FSZ)
   ) u_fifo (
      .i_clk   (i_clk),
      .reset_n (reset_n),
      .push    (fifo_push),
      .din     (full_msg),
      .pop     (fifo_pop),
      .head    (fifo_head),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign o_rcv_ack  = (in_st_q == I_ACK);
   assign o_snd_msg  = snd_msg_q;
   assign o_snd_req  = snd_req_q;
   assign o_err_cnt  = err_cnt_q;
   assign o_dbg_leds = {(err_cnt_q != 8'd0), i_rcv_req, fifo_full, fifo_empty};

endmodule

// File: tb/tb_pakin.sv
// Scoreboard bench for pakin: stimulus queues expected messages, an output-side
// monitor performs the message handshake and compares each delivered message.
module tb_pakin;

   logic        i_clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [4:0]  i_rcv_pakio = '0;
   logic        i_rcv_req = 1'b0;
   logic        o_rcv_ack;
   logic [19:0] o_snd_msg;
   logic        o_snd_req;
   logic        i_snd_ack = 1'b0;
   logic [7:0]  o_err_cnt;
   logic [3:0]  o_dbg_leds;

   int          n_chk = 0;
   int          n_fail = 0;
   int          delivered = 0;
   bit          hold_ack = 1'b1;
   logic [19:0] exp_q[$];

   always #5 i_clk = ~i_clk;

   pakin dut (
      .i_clk       (i_clk),
      .reset_n     (reset_n),
      .i_rcv_pakio (i_rcv_pakio),
      .i_rcv_req   (i_rcv_req),
      .o_rcv_ack   (o_rcv_ack),
      .o_snd_msg   (o_snd_msg),
      .o_snd_req   (o_snd_req),
      .i_snd_ack   (i_snd_ack),
      .o_err_cnt   (o_err_cnt),
      .o_dbg_leds  (o_dbg_leds)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic wait_ack(input logic lvl, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (o_rcv_ack === lvl) begin
            ok = 1'b1;
            break;
         end
         @(negedge i_clk);
      end
   endtask

   task automatic send_pkt(input logic [4:0] p);
      bit ok;
      @(negedge i_clk);
      i_rcv_pakio = p;
      i_rcv_req   = 1'b1;
      wait_ack(1'b1, ok);
      chk("rcv_ack_rise", ok, 1);
      i_rcv_req = 1'b0;
      wait_ack(1'b0, ok);
      chk("rcv_ack_fall", ok, 1);
   endtask

   task automatic send_msg(input logic [19:0] m, input bit good);
      if (good) exp_q.push_back(m);
      for (int k = 3; k >= 0; k--) send_pkt(m[k*5 +: 5]);
   endtask

   task automatic drain();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge i_clk);
         if (exp_q.size() == 0 && !o_snd_req && !i_snd_ack) begin
            ok = 1'b1;
            break;
         end
      end
      chk("drain", ok, 1);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_rcv_ack"}, o_rcv_ack, 0);
      chk({tag, "_snd_req"}, o_snd_req, 0);
      chk({tag, "_snd_msg"}, o_snd_msg, 0);
      chk({tag, "_err_cnt"}, o_err_cnt, 0);
      chk({tag, "_leds"}, o_dbg_leds, 4'b0001);
   endtask

   // Output-side monitor: acks each presented message once and scores it.
   initial begin
      forever begin
         @(posedge i_clk);
         #1;
         if (!reset_n) begin
            i_snd_ack = 1'b0;
         end else if (i_snd_ack && !o_snd_req) begin
            i_snd_ack = 1'b0;
         end else if (!i_snd_ack && o_snd_req && !hold_ack) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_msg", o_snd_msg, 20'hxxxxx);
            end else begin
               chk("snd_msg", o_snd_msg, exp_q.pop_front());
            end
            delivered++;
            i_snd_ack = 1'b1;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      bit          ok;
      int          d0;
      logic [19:0] m5;

      repeat (3) @(negedge i_clk);
      reset_n = 1'b1;
      @(negedge i_clk);
      chk_reset_vals("rst");

      // good message then a bad one, then normal traffic resumes
      hold_ack = 1'b0;
      send_msg(20'h0C25A, 1);
      drain();
      chk("good_err_cnt", o_err_cnt, 0);

      send_msg(20'h0C25F, 0);
      repeat (4) @(negedge i_clk);
      chk("bad_no_req", o_snd_req, 0);
      chk("bad_err_cnt", o_err_cnt, 1);
      chk("bad_led3", o_dbg_leds[3], 1);
      send_msg(20'h04113, 1);
      send_msg(20'hFC1FF, 1);
      drain();

      // back-pressure: four fill the FIFO, last packet of the fifth stalls
      hold_ack = 1'b1;
      d0 = delivered;
      send_msg(20'h0C25A, 1);
      send_msg(20'hA950F, 1);
      send_msg(20'h00000, 1);
      send_msg(20'h29431, 1);
      repeat (3) @(negedge i_clk);
      chk("bp_full", o_dbg_leds[1], 1);
      chk("bp_req", o_snd_req, 1);
      chk("bp_head", o_snd_msg, 20'h0C25A);
      m5 = 20'h04113;
      exp_q.push_back(m5);
      for (int k = 3; k >= 1; k--) send_pkt(m5[k*5 +: 5]);
      @(negedge i_clk);
      i_rcv_pakio = m5[4:0];
      i_rcv_req   = 1'b1;
      repeat (8) @(negedge i_clk);
      chk("bp_stall_ack", o_rcv_ack, 0);
      hold_ack = 1'b0;
      wait_ack(1'b1, ok);
      chk("bp_release_ack", ok, 1);
      i_rcv_req = 1'b0;
      wait_ack(1'b0, ok);
      chk("bp_release_fall", ok, 1);
      drain();
      chk("bp_delivered", delivered - d0, 5);

      // push and pop on the same edge while full
      hold_ack = 1'b1;
      send_msg(20'hA950F, 1);
      send_msg(20'h29431, 1);
      send_msg(20'h0C25A, 1);
      send_msg(20'hFC1FF, 1);
      m5 = 20'h00000;
      exp_q.push_back(m5);
      for (int k = 3; k >= 1; k--) send_pkt(m5[k*5 +: 5]);
      repeat (3) @(negedge i_clk);
      chk("sim_full_before", o_dbg_leds[1], 1);
      hold_ack = 1'b0;
      @(negedge i_clk);
      i_rcv_pakio = m5[4:0];
      i_rcv_req   = 1'b1;
      @(negedge i_clk);
      chk("sim_no_stall", o_rcv_ack, 1);
      chk("sim_full_after", o_dbg_leds[1], 1);
      i_rcv_req = 1'b0;
      wait_ack(1'b0, ok);
      chk("sim_ack_fall", ok, 1);
      drain();

      // reset in the middle of a message
      send_pkt(5'h01);
      send_pkt(5'h10);
      #3 reset_n = 1'b0;
      #1 chk_reset_vals("mid_rst");
      @(negedge i_clk);
      reset_n = 1'b1;
      @(negedge i_clk);
      chk_reset_vals("mid_rel");
      send_msg(20'h0C25A, 1);
      drain();

      // error counter saturation
      for (int n = 0; n < 260; n++) send_msg(20'h0C25F, 0);
      repeat (3) @(negedge i_clk);
      chk("sat_err_cnt", o_err_cnt, 255);
      chk("sat_led3", o_dbg_leds[3], 1);
      chk("sat_no_req", o_snd_req, 0);
      chk("sat_empty", o_dbg_leds[0], 1);

      chk("scoreboard_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
